// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd6;
  localparam logic [OP_W-1:0] OP_NOR  = 4'd7;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd9;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd10;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd11;
  localparam logic [OP_W-1:0] OP_DIVU = 4'd12;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) datapath.
// One step per enabled clock; lo/hi present the values after the current step.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             step_en,
  output logic             last,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] acc_step, mq_step;

  // acc holds the product high half / partial remainder, mq the multiplier / quotient
  always_comb begin
    sum     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_q, mq_q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - opnd_q;
    if (div_q) begin
      if (shifted >= {1'b0, opnd_q}) begin
        acc_step = diff;
        mq_step  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = shifted[WIDTH-1:0];
        mq_step  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = sum[WIDTH:1];
      mq_step  = {sum[0], mq_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mq_d   = mq_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    if (load) begin
      cnt_d  = CW'(WIDTH);
      acc_d  = '0;
      mq_d   = op_div ? a : b;
      opnd_d = op_div ? b : a;
      div_d  = op_div;
    end else if (step_en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = acc_step;
      mq_d  = mq_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      mq_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mq_q   <= mq_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
    end
  end

  assign last = (cnt_q == CW'(1));
  assign lo   = mq_step;
  assign hi   = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Parametrised EX-stage ALU: single-cycle logic/arith ops plus iterative
// MUL/DIVU behind a start/busy/done handshake. All outputs are registered.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] rega,
  input  logic [WIDTH-1:0] regb,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  state_t state_q, state_d;

  logic             is_iter;
  logic             load, step_en, fin_single, fin_iter;
  logic             last;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic             dz_pend_q, dz_pend_d;

  logic [WIDTH-1:0] sum_ab, diff_ab, alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  assign is_iter = (alu_op == OP_MUL) || (alu_op == OP_DIVU);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .op_div  (alu_op == OP_DIVU),
    .a       (rega),
    .b       (regb),
    .step_en (step_en),
    .last    (last),
    .lo      (it_lo),
    .hi      (it_hi)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && is_iter) state_d = BUSY;
      BUSY:    if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    step_en    = 1'b0;
    fin_single = 1'b0;
    fin_iter   = 1'b0;
    case (state_q)
      IDLE: begin
        load       = start && is_iter;
        fin_single = start && !is_iter;
      end
      BUSY: begin
        step_en  = 1'b1;
        fin_iter = last;
      end
      default: ;
    endcase
  end

  always_comb begin
    sum_ab  = rega + regb;
    diff_ab = rega - regb;
    shamt   = regb[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = sum_ab;
        alu_ovf = (rega[WIDTH-1] == regb[WIDTH-1]) && (sum_ab[WIDTH-1] != rega[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_ab;
        alu_ovf = (rega[WIDTH-1] != regb[WIDTH-1]) && (diff_ab[WIDTH-1] != rega[WIDTH-1]);
      end
      OP_AND:  alu_res = rega & regb;
      OP_OR:   alu_res = rega | regb;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (rega < regb)};
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(rega) < $signed(regb))};
      OP_XOR:  alu_res = rega ^ regb;
      OP_NOR:  alu_res = ~(rega | regb);
      OP_SLL:  alu_res = rega << shamt;
      OP_SRL:  alu_res = rega >> shamt;
      OP_SRA:  alu_res = $signed(rega) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // divide-by-zero is decided from the operand captured at the start edge
  assign dz_pend_d = load ? ((alu_op == OP_DIVU) && (regb == '0)) : dz_pend_q;

  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    done_d      = 1'b0;
    busy_d      = (state_d == BUSY);
    if (fin_single) begin
      result_d    = alu_res;
      result_hi_d = '0;
      zero_d      = (alu_res == '0);
      ovf_d       = alu_ovf;
      dz_d        = 1'b0;
      done_d      = 1'b1;
    end else if (fin_iter) begin
      result_d    = it_lo;
      result_hi_d = it_hi;
      zero_d      = (it_lo == '0);
      ovf_d       = 1'b0;
      dz_d        = dz_pend_q;
      done_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_pend_q   <= 1'b0;
    end else begin
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_pend_q   <= dz_pend_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: expected results are queued at issue time and
// popped and compared when done pulses.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W       = 32;
  localparam int TIMEOUT = 100;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         dz;
    int           lat;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [OP_W-1:0] aluOp;
  logic [W-1:0]    regA, regB;
  logic [W-1:0]    result, resultHi;
  logic            zero, overflow, divZero, busy, done;

  exp_t sb[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .alu_op    (aluOp),
    .rega      (regA),
    .regb      (regB),
    .result    (result),
    .result_hi (resultHi),
    .zero      (zero),
    .overflow  (overflow),
    .div_zero  (divZero),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    testsRun++;
    assert (got === want) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic checkBit(input string tag, input logic got, input logic want);
    testsRun++;
    assert (got === want) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, got, want);
    end
  endtask

  task automatic checkInt(input string tag, input int got, input int want);
    testsRun++;
    assert (got == want) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after the start edge.
  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic [W-1:0] hi,
                               input logic z, input logic ovf, input logic dz, input int lat);
    exp_t e;
    e.res = res; e.hi = hi; e.zero = z; e.ovf = ovf; e.dz = dz; e.lat = lat;
    sb.push_back(e);
    start = 1'b1;
    aluOp = op;
    regA  = a;
    regB  = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, counting edges after the start edge and busy cycles.
  // At edge count injectAt an ADD 1+1 start is driven, which must be ignored.
  task automatic checkOutput(input string tag, input int injectAt);
    exp_t e;
    int   lat = 0;
    int   busyCycles = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      if (busy === 1'b1) busyCycles++;
      if (lat == injectAt) begin
        start = 1'b1;
        aluOp = OP_ADD;
        regA  = 1;
        regB  = 1;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    checkBit({tag, "/done"}, done, 1'b1);
    if (done !== 1'b1) begin
      sb.delete();
      return;
    end
    checkInt({tag, "/pending"}, sb.size(), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    checkValue({tag, "/result"}, result, e.res);
    checkValue({tag, "/result_hi"}, resultHi, e.hi);
    checkBit({tag, "/zero"}, zero, e.zero);
    checkBit({tag, "/overflow"}, overflow, e.ovf);
    checkBit({tag, "/div_zero"}, divZero, e.dz);
    checkInt({tag, "/latency"}, lat, e.lat);
    checkInt({tag, "/busyCycles"}, busyCycles, e.lat);
    checkBit({tag, "/busyAtDone"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawDone;
    reset = 1'b1;
    start = 1'b0;
    aluOp = '0;
    regA  = '0;
    regB  = '0;
    @(negedge clk);
    @(negedge clk);
    checkValue("reset/result", result, 32'h0);
    checkValue("reset/result_hi", resultHi, 32'h0);
    checkBit("reset/busy", busy, 1'b0);
    checkBit("reset/done", done, 1'b0);
    checkBit("reset/div_zero", divZero, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("XOR", -1);

    // Abort a DIVU with reset at cycle 5: no done, outputs cleared
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, W);
    repeat (4) @(negedge clk);
    checkBit("abort/busyBefore", busy, 1'b1);
    reset = 1'b1;
    #1;
    checkBit("abort/busy", busy, 1'b0);
    checkValue("abort/result", result, 32'h0);
    checkBit("abort/done", done, 1'b0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkBit("abort/noDonePulse", sawDone, 1'b0);
    checkBit("abort/idle", busy, 1'b0);

    applyStimulus(OP_ADD, 32'd3, 32'd4, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("ADD3+4", -1);
    applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'd1, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("ADDovf", -1);
    applyStimulus(OP_SUB, 32'd5, 32'd5, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("SUB5-5", -1);
    applyStimulus(OP_SUB, 32'h80000000, 32'd1, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("SUBovf", -1);
    applyStimulus(OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("SLT", -1);
    applyStimulus(OP_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("SLTU", -1);
    applyStimulus(OP_SRA, 32'h80000000, 32'd4, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("SRA", -1);
    applyStimulus(OP_SRL, 32'h80000000, 32'd4, 32'h08000000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("SRL", -1);
    applyStimulus(OP_SLL, 32'd1, 32'd33, 32'd2, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("SLLmask", -1);
    applyStimulus(OP_NOR, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("NOR", -1);

    // MUL with an ignored second start (and changed operands) at cycle 10
    applyStimulus(OP_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'd1, 1'b0, 1'b0, 1'b0, W);
    checkOutput("MUL", 9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkBit("MUL/noExtraDone", done, 1'b0);
    end

    applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, W);
    checkOutput("DIVU100/7", -1);
    applyStimulus(OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 32'd9, 1'b0, 1'b0, 1'b1, W);
    checkOutput("DIVU9/0", -1);
    applyStimulus(OP_AND, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("ANDclearsDz", -1);
    applyStimulus(4'd14, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("ILLEGAL14", -1);

    @(negedge clk);
    checkBit("final/doneLow", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
